// File: rtl/crc8_serial_checker_if.sv
// rtl/crc8_serial_checker_if.sv - serial CRC-8 checker stream/status bundle
//
// Groups the serial receive inputs and the per-frame status outputs of
// crc8_serial_checker.
//   master : drives Data/Active/Crc_In/Crc_Valid, observes status
//   slave  : the checker itself
// Signals:
//   Data, Active       serial data bit and its phase qualifier
//   Crc_In, Crc_Valid  serial received CRC bit (MSB first) and qualifier
//   Busy               frame in DATA or CHECK
//   Done/Crc_Ok/Crc_Err/Abort  one-cycle result pulses
//   Frame_Len          data-bit length of the last completed frame
//   Err_Cnt            saturating Crc_Err count (zero unless enabled)

interface crc8_serial_checker_if #(
    parameter int LEN_W = 16
);
    logic             Data;
    logic             Active;
    logic             Crc_In;
    logic             Crc_Valid;
    logic             Busy;
    logic             Done;
    logic             Crc_Ok;
    logic             Crc_Err;
    logic             Abort;
    logic [LEN_W-1:0] Frame_Len;
    logic [7:0]       Err_Cnt;

    modport master (
        output Data, Active, Crc_In, Crc_Valid,
        input  Busy, Done, Crc_Ok, Crc_Err, Abort, Frame_Len, Err_Cnt
    );

    modport slave (
        input  Data, Active, Crc_In, Crc_Valid,
        output Busy, Done, Crc_Ok, Crc_Err, Abort, Frame_Len, Err_Cnt
    );
endinterface

// File: rtl/crc8_serial_checker.sv
// rtl/crc8_serial_checker.sv - serial CRC-8 receive checker with per-frame status
//
// Recomputes the CRC-8 over a serial data stream and compares it bit by bit
// with the 8 received CRC bits (MSB first) that follow the data.
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-low reset
//   bus  crc8_serial_checker_if.slave (stream inputs, status outputs)
// Parameters:
//   SEED   LFSR initial value, must match the generator
//   LEN_W  width of the data-bit length counter
// Optional feature macro:
//   CRC_CHK_ERR_CNT_EN  builds the saturating Crc_Err event counter;
//                       without it Err_Cnt is tied to zero.

module crc8_serial_checker #(
    parameter logic [7:0] SEED  = 8'h8E,
    parameter int         LEN_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    crc8_serial_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_lfsr;
    logic [3:0]       r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_mis;
    logic             r_done;
    logic             r_ok;
    logic             r_err;
    logic             r_abort;
    logic [LEN_W-1:0] r_frame_len;

    state_t           w_state;
    logic [7:0]       w_lfsr;
    logic [3:0]       w_cnt;
    logic [LEN_W-1:0] w_len;
    logic             w_mis;
    logic             w_done;
    logic             w_ok;
    logic             w_err;
    logic             w_abort;
    logic [LEN_W-1:0] w_frame_len;

    logic [7:0]       w_lfsr_step;
    logic [7:0]       w_lfsr_start;
    logic [7:0]       w_lfsr_shift;
    logic             w_bit_mis;
    logic             w_mis_acc;
    logic [LEN_W-1:0] w_len_inc;

    // One data bit through the LFSR; feedback is purely combinational.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic d);
        logic fb;
        fb = l[0] ^ d;
        return {fb, fb ^ l[7], l[6], l[5], l[4], fb ^ l[3], l[2], l[1]};
    endfunction

    assign w_lfsr_step  = lfsr_step(r_lfsr, bus.Data);
    // Every frame start counts the current Data as bit 1 from a fresh seed,
    // so IDLE, HOLD and the abort path share one start value.
    assign w_lfsr_start = lfsr_step(SEED, bus.Data);
    assign w_lfsr_shift = {r_lfsr[6:0], 1'b0};
    assign w_bit_mis    = bus.Crc_In ^ r_lfsr[7];
    assign w_mis_acc    = r_mis | w_bit_mis;
    assign w_len_inc    = (r_len == {LEN_W{1'b1}}) ? r_len : r_len + LEN_W'(1);

    always_comb begin
        w_state     = r_state;
        w_lfsr      = r_lfsr;
        w_cnt       = r_cnt;
        w_len       = r_len;
        w_mis       = r_mis;
        w_done      = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_abort     = 1'b0;
        w_frame_len = r_frame_len;

        if (bus.Active && r_state != ST_DATA) begin
            // Frame start from IDLE/HOLD, or an abort out of CHECK.
            w_abort = (r_state == ST_CHECK);
            w_state = ST_DATA;
            w_lfsr  = w_lfsr_start;
            w_len   = LEN_W'(1);
            w_cnt   = 4'd0;
            w_mis   = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.Crc_Valid) begin
                        // Empty frame: the CRC phase starts with no data bits.
                        w_state = ST_CHECK;
                        w_mis   = w_bit_mis;
                        w_lfsr  = w_lfsr_shift;
                        w_cnt   = 4'd1;
                        w_len   = '0;
                    end
                end
                ST_DATA: begin
                    if (bus.Active) begin
                        w_lfsr = w_lfsr_step;
                        w_len  = w_len_inc;
                    end else if (bus.Crc_Valid) begin
                        w_state = ST_CHECK;
                        w_mis   = w_bit_mis;
                        w_lfsr  = w_lfsr_shift;
                        w_cnt   = 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (bus.Crc_Valid) begin
                        w_mis  = w_mis_acc;
                        w_lfsr = w_lfsr_shift;
                        w_cnt  = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_done      = 1'b1;
                            w_ok        = ~w_mis_acc;
                            w_err       = w_mis_acc;
                            w_frame_len = r_len;
                            w_lfsr      = SEED;
                            w_state     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Crc_Valid may linger after the 8th bit; wait it out.
                    if (!bus.Crc_Valid) begin
                        w_state = ST_IDLE;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= SEED;
            r_cnt       <= 4'd0;
            r_len       <= '0;
            r_mis       <= 1'b0;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
            r_frame_len <= '0;
        end else begin
            r_state     <= w_state;
            r_lfsr      <= w_lfsr;
            r_cnt       <= w_cnt;
            r_len       <= w_len;
            r_mis       <= w_mis;
            r_done      <= w_done;
            r_ok        <= w_ok;
            r_err       <= w_err;
            r_abort     <= w_abort;
            r_frame_len <= w_frame_len;
        end
    end

`ifdef CRC_CHK_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Counts alongside the registered Crc_Err so both appear together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err_cnt <= 8'h00;
        end else if (w_err && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign bus.Err_Cnt = r_err_cnt;
`else
    assign bus.Err_Cnt = 8'h00;
`endif

    assign bus.Busy      = (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign bus.Done      = r_done;
    assign bus.Crc_Ok    = r_ok;
    assign bus.Crc_Err   = r_err;
    assign bus.Abort     = r_abort;
    assign bus.Frame_Len = r_frame_len;

endmodule

// File: tb/tb_crc8_serial_checker.sv
// tb/tb_crc8_serial_checker.sv - scoreboard bench for crc8_serial_checker

module tb_crc8_serial_checker;

    localparam logic [7:0] SEED  = 8'h8E;
    localparam int         LEN_W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    crc8_serial_checker_if #(.LEN_W(LEN_W)) bus ();

    crc8_serial_checker #(.SEED(SEED), .LEN_W(LEN_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic             abort;
        logic             ok;
        logic [LEN_W-1:0] len;
        logic [7:0]       ecnt;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   exp_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference CRC: the LFSR written out bit by bit, data bit i sent i-th.
    function automatic logic [7:0] crc_model(input logic [31:0] d, input int n);
        logic [7:0] l;
        logic [7:0] nx;
        logic       fb;
        l = SEED;
        for (int i = 0; i < n; i++) begin
            fb    = l[0] ^ d[i];
            nx[7] = fb;
            nx[6] = fb ^ l[7];
            nx[5] = l[6];
            nx[4] = l[5];
            nx[3] = l[4];
            nx[2] = fb ^ l[3];
            nx[1] = l[2];
            nx[0] = l[1];
            l     = nx;
        end
        return l;
    endfunction

    task automatic step(input logic a, input logic d, input logic v, input logic c);
        bus.Active    = a;
        bus.Data      = d;
        bus.Crc_Valid = v;
        bus.Crc_In    = c;
        @(negedge CLK);
    endtask

    // Expected result becomes visible in the cycle after the next edge.
    task automatic push(input logic abort, input logic ok, input int len);
        exp_t e;
        e.abort = abort;
        e.ok    = ok;
        e.len   = len[LEN_W-1:0];
        if (!abort && !ok && exp_err < 255) exp_err++;
`ifdef CRC_CHK_ERR_CNT_EN
        e.ecnt = exp_err[7:0];
`else
        e.ecnt = 8'h00;
`endif
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Sends n data bits then CRC bits. stall_at/abort_at index the CRC bit
    // before which the stall or early return happens (-1 for none).
    task automatic send_frame(input logic [31:0] d, input int n, input logic [7:0] crc,
                              input int stall_at, input int stall_len, input int abort_at,
                              input int extra_valid, input logic first_aborts);
        for (int i = 0; i < n; i++) begin
            if (i == 0 && first_aborts) push(1'b1, 1'b0, 0);
            step(1'b1, d[i], 1'b0, 1'b0);
        end
        for (int j = 0; j < 8; j++) begin
            if (j == abort_at) return;
            if (j == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    n_cmp++;
                    if (bus.Busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stall_busy: got %b want 1", bus.Busy);
                    end
                end
            end
            if (j == 7) push(1'b0, crc == crc_model(d, n), n);
            step(1'b0, 1'b0, 1'b1, crc[7-j]);
        end
        for (int k = 0; k < extra_valid; k++) step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (bus.Done || bus.Abort) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: done=%b abort=%b want none", bus.Done, bus.Abort);
                end else begin
                    mon_e = sb.pop_front();
                    if ({bus.Abort, bus.Done, bus.Crc_Ok, bus.Crc_Err} !==
                        {mon_e.abort, !mon_e.abort, !mon_e.abort && mon_e.ok, !mon_e.abort && !mon_e.ok}) begin
                        n_bad++;
                        $display("FAIL result_flags: abort/done/ok/err=%b%b%b%b want %b%b%b%b",
                                 bus.Abort, bus.Done, bus.Crc_Ok, bus.Crc_Err,
                                 mon_e.abort, !mon_e.abort, !mon_e.abort && mon_e.ok, !mon_e.abort && !mon_e.ok);
                    end
                    n_cmp++;
                    if (cyc !== mon_e.cyc) begin
                        n_bad++;
                        $display("FAIL result_cycle: got %0d want %0d", cyc, mon_e.cyc);
                    end
                    if (!mon_e.abort) begin
                        n_cmp++;
                        if (bus.Frame_Len !== mon_e.len) begin
                            n_bad++;
                            $display("FAIL frame_len: got %0d want %0d", bus.Frame_Len, mon_e.len);
                        end
                        n_cmp++;
                        if (bus.Err_Cnt !== mon_e.ecnt) begin
                            n_bad++;
                            $display("FAIL err_cnt: got %0d want %0d", bus.Err_Cnt, mon_e.ecnt);
                        end
                    end
                end
            end else if (bus.Crc_Ok || bus.Crc_Err) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_result: ok=%b err=%b without done", bus.Crc_Ok, bus.Crc_Err);
            end
        end
    end

    task automatic test_reset();
        RST = 1'b0;
        bus.Active = 1'b0; bus.Data = 1'b0; bus.Crc_Valid = 1'b0; bus.Crc_In = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.Crc_Ok, bus.Crc_Err, bus.Abort} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.Busy, bus.Done, bus.Crc_Ok, bus.Crc_Err, bus.Abort});
        end
        n_cmp++;
        if (bus.Frame_Len !== '0) begin
            n_bad++;
            $display("FAIL reset_len: got %0d want 0", bus.Frame_Len);
        end
        n_cmp++;
        if (bus.Err_Cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_errcnt: got %0d want 0", bus.Err_Cnt);
        end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_empty_frame();
        send_frame(32'h0, 0, SEED, -1, 0, -1, 0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_data_frame();
        logic [7:0] good;
        good = crc_model(32'b1101, 4);
        send_frame(32'b1101, 4, good, -1, 0, -1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_busy: got %b want 0", bus.Busy);
        end
        send_frame(32'b1101, 4, good ^ 8'h01, -1, 0, -1, 0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_crc_stall();
        send_frame(32'b1101, 4, crc_model(32'b1101, 4), 3, 3, -1, 0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        send_frame(32'b1101, 4, crc_model(32'b1101, 4), -1, 0, 5, 0, 1'b0);
        send_frame(32'b1101, 4, crc_model(32'b1101, 4), -1, 0, -1, 0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_frame(32'h5A3, 12, crc_model(32'h5A3, 12), -1, 0, -1, 20, 1'b0);
        send_frame(32'h0F0F1, 20, crc_model(32'h0F0F1, 20), -1, 0, -1, 0, 1'b0);
        send_frame(32'h7, 3, crc_model(32'h7, 3) ^ 8'h40, -1, 0, -1, 0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [31:0] d;
        logic [7:0]  c;
        int          n;
        for (int r = 0; r < 6; r++) begin
            d = $urandom;
            n = $urandom_range(1, 32);
            c = crc_model(d, n);
            if (r[0]) c = c ^ (8'h01 << $urandom_range(0, 7));
            send_frame(d, n, c, -1, 0, -1, $urandom_range(0, 2), 1'b0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bus.Active = 1'b1; bus.Data = 1'b1;
        #2 RST = 1'b0;
        #1;
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.Crc_Ok, bus.Crc_Err, bus.Abort} !== 5'b0) begin
            n_bad++;
            $display("FAIL midreset_flags: got %b want 00000",
                     {bus.Busy, bus.Done, bus.Crc_Ok, bus.Crc_Err, bus.Abort});
        end
        n_cmp++;
        if (bus.Frame_Len !== '0 || bus.Err_Cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_counts: len=%0d errcnt=%0d want 0 0", bus.Frame_Len, bus.Err_Cnt);
        end
        exp_err = 0;
        bus.Active = 1'b0; bus.Data = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send_frame(32'b1101, 4, crc_model(32'b1101, 4), -1, 0, -1, 0, 1'b0);
        send_frame(32'h3C, 7, crc_model(32'h3C, 7) ^ 8'h80, -1, 0, -1, 0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_empty_frame();
        test_data_frame();
        test_crc_stall();
        test_abort();
        test_back_to_back();
        test_random_frames();
        test_reset_mid_frame();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL pending_results: %0d expected events never seen, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
